// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioning stage:
//   - debounce FSM state encoding
//   - default screen limits and debounce length
//   - unsigned 12-bit clamp helper used on the pointer position
package input_cond_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } db_state_e;

    localparam int unsigned HMaxDefault           = 1023;
    localparam int unsigned VMaxDefault           = 767;
    localparam int unsigned DebounceCyclesDefault = 650000;  // 10 ms at 65 MHz

    function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/input_cond_sync_edge.sv
// Synchroniser chain followed by a registered rising-edge detector.
//   clk      : destination clock
//   rst      : asynchronous, active-low reset
//   d_i      : asynchronous input level
//   level_o  : synchronised level (last chain stage)
//   rise_o   : one-cycle pulse, registered, on each synchronised 0->1 transition
module input_cond_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   rise_d;

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_d  = level_o & ~prev_q;
    assign rise_o  = rise_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= level_o;
            rise_q <= rise_d;
        end
    end

endmodule

// File: rtl/input_cond.sv
// Input conditioning ahead of the screen/state controller.
//   clk            : pixel clock
//   rst            : asynchronous, active-low reset
//   mouse_left_raw : async mouse left-button level -> mouse_left one-cycle press pulse
//   button_raw     : async bouncy pushbutton       -> button one-cycle debounced press pulse
//   xpos_raw/ypos_raw : async pointer position     -> xpos/ypos, latched on vsync_in rise
//                       and clamped to H_MAX/V_MAX
//   vsync_in       : frame sync, already in clk domain
module input_cond
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned H_MAX           = HMaxDefault,
    parameter int unsigned V_MAX           = VMaxDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left_raw,
    input  logic        button_raw,
    input  logic [11:0] xpos_raw,
    input  logic [11:0] ypos_raw,
    input  logic        vsync_in,
    output logic        mouse_left,
    output logic        button,
    output logic [11:0] xpos,
    output logic [11:0] ypos
);

    localparam int unsigned      CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(DEBOUNCE_CYCLES);
    localparam logic [11:0]      HLim   = 12'(H_MAX);
    localparam logic [11:0]      VLim   = 12'(V_MAX);

    // Click path: synchronise and take the rising edge.
    logic click_level;
    logic btn_sync;
    logic btn_rise;

    input_cond_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_click_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (mouse_left_raw),
        .level_o(click_level),
        .rise_o (mouse_left)
    );

    // Button path: only the synchronised level is used; the FSM makes the pulse.
    input_cond_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (button_raw),
        .level_o(btn_sync),
        .rise_o (btn_rise)
    );

    logic sync_unused;
    assign sync_unused = click_level ^ btn_rise;

    // Debounce FSM. Counter only advances below CntMax, so it can never wrap.
    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic            button_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            button_q <= 1'b0;
        end else begin
            button_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (btn_sync) begin
                        state_q <= StPressWait;
                        cnt_q   <= CntW'(1);
                    end
                end
                StPressWait: begin
                    if (!btn_sync) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q  <= StPressed;
                        button_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!btn_sync) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= CntW'(1);
                    end
                end
                StReleaseWait: begin
                    // Bounce back high returns to PRESSED silently.
                    if (btn_sync) begin
                        state_q <= StPressed;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign button = button_q;

    // Position path: two plain capture stages; bus skew is harmless because only
    // the value present at the vsync edge is used.
    logic [11:0] x_s1_q, x_s2_q, y_s1_q, y_s2_q;
    logic [11:0] xpos_q, ypos_q;
    logic        vsync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_s1_q  <= '0;
            x_s2_q  <= '0;
            y_s1_q  <= '0;
            y_s2_q  <= '0;
            vsync_q <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
        end else begin
            x_s1_q  <= xpos_raw;
            x_s2_q  <= x_s1_q;
            y_s1_q  <= ypos_raw;
            y_s2_q  <= y_s1_q;
            vsync_q <= vsync_in;
            if (vsync_in && !vsync_q) begin
                xpos_q <= clamp12(x_s2_q, HLim);
                ypos_q <= clamp12(y_s2_q, VLim);
            end
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;

endmodule

// File: tb/tb_input_cond.sv
module tb_input_cond;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mouse_left_raw = 1'b0;
    logic        button_raw = 1'b0;
    logic [11:0] xpos_raw = '0;
    logic [11:0] ypos_raw = '0;
    logic        vsync_in = 1'b0;
    logic        mouse_left;
    logic        button;
    logic [11:0] xpos;
    logic [11:0] ypos;

    int errors = 0;
    int checks = 0;

    input_cond #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .H_MAX          (1023),
        .V_MAX          (767)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mouse_left_raw(mouse_left_raw),
        .button_raw    (button_raw),
        .xpos_raw      (xpos_raw),
        .ypos_raw      (ypos_raw),
        .vsync_in      (vsync_in),
        .mouse_left    (mouse_left),
        .button        (button),
        .xpos          (xpos),
        .ypos          (ypos)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mouse_left !== 1'b0) begin errors++; $display("FAIL reset_mouse_left: got %b expected 0", mouse_left); end
        checks++; if (button !== 1'b0) begin errors++; $display("FAIL reset_button: got %b expected 0", button); end
        checks++; if (xpos !== 12'd0) begin errors++; $display("FAIL reset_xpos: got %0d expected 0", xpos); end
        checks++; if (ypos !== 12'd0) begin errors++; $display("FAIL reset_ypos: got %0d expected 0", ypos); end
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (mouse_left !== 1'b0 || button !== 1'b0) begin
            errors++; $display("FAIL post_reset_pulses: got %b/%b expected 0/0", mouse_left, button);
        end
        @(negedge clk) vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (xpos !== 12'd0 || ypos !== 12'd0) begin
            errors++; $display("FAIL reset_vsync_pos: got %0d/%0d expected 0/0", xpos, ypos);
        end
        @(negedge clk) vsync_in = 1'b0;
    endtask

    task automatic test_click();
        int pulses;
        int first;
        for (int rep = 0; rep < 2; rep++) begin
            pulses = 0;
            first  = 0;
            @(negedge clk) mouse_left_raw = 1'b1;
            for (int i = 1; i <= 50; i++) begin
                @(posedge clk); #1;
                if (mouse_left) begin
                    pulses++;
                    if (first == 0) first = i;
                end
            end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL click_count_%0d: got %0d expected 1", rep, pulses); end
            checks++; if (first !== 3) begin errors++; $display("FAIL click_latency_%0d: got %0d expected 3", rep, first); end
            @(negedge clk) mouse_left_raw = 1'b0;
            pulses = 0;
            for (int i = 1; i <= 5; i++) begin
                @(posedge clk); #1;
                if (mouse_left) pulses++;
            end
            checks++; if (pulses !== 0) begin errors++; $display("FAIL click_release_%0d: got %0d pulses expected 0", rep, pulses); end
        end
    endtask

    task automatic test_button_bounce();
        logic pat [12];
        int pulses;
        int first;
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        pulses = 0;
        first  = -1;
        // Final stable rise at i=12; 2 sync stages + 16 stable counts -> pulse at i=30.
        for (int i = 0; i < 52; i++) begin
            @(negedge clk) button_raw = (i < 12) ? pat[i] : 1'b1;
            @(posedge clk); #1;
            if (button) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", pulses); end
        checks++; if (first !== 30) begin errors++; $display("FAIL bounce_press_time: got %0d expected 30", first); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) button_raw = (i >= 3 && i <= 5) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (button) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_release: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_button_short();
        int pulses;
        int first;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) button_raw = (i < 10) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (button) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL short_press: got %0d pulses expected 0", pulses); end
        // A following full press must take the full time from IDLE.
        pulses = 0;
        first  = 0;
        @(negedge clk) button_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (button) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++; if (pulses !== 1 || first !== 19) begin
            errors++; $display("FAIL short_then_full: got %0d pulses at %0d expected 1 at 19", pulses, first);
        end
        @(negedge clk) button_raw = 1'b0;
        repeat (30) @(posedge clk);
    endtask

    task automatic test_position();
        logic [11:0] xr [6];
        logic [11:0] yr [6];
        logic [11:0] xe [6];
        logic [11:0] ye [6];
        logic [11:0] px;
        logic [11:0] py;
        xr = '{12'd500, 12'd2000, 12'd1022, 12'd1024, 12'd0, 12'd1023};
        yr = '{12'd300, 12'd4095, 12'd766,  12'd768,  12'd0, 12'd767};
        xe = '{12'd500, 12'd1023, 12'd1022, 12'd1023, 12'd0, 12'd1023};
        ye = '{12'd300, 12'd767,  12'd766,  12'd767,  12'd0, 12'd767};
        px = 12'd0;
        py = 12'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            xpos_raw = xr[k];
            ypos_raw = yr[k];
            repeat (5) @(posedge clk);
            #1;
            checks++; if (xpos !== px || ypos !== py) begin
                errors++; $display("FAIL pos_hold_%0d: got %0d/%0d expected %0d/%0d", k, xpos, ypos, px, py);
            end
            @(negedge clk) vsync_in = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            checks++; if (xpos !== xe[k] || ypos !== ye[k]) begin
                errors++; $display("FAIL pos_latch_%0d: got %0d/%0d expected %0d/%0d", k, xpos, ypos, xe[k], ye[k]);
            end
            @(negedge clk) vsync_in = 1'b0;
            repeat (2) @(posedge clk);
            px = xe[k];
            py = ye[k];
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pulses;
        int first;
        pulses = 0;
        @(negedge clk) button_raw = 1'b1;
        // Count is 10 after the 12th edge.
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (button) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_pre_reset: got %0d pulses expected 0", pulses); end
        #1 rst = 1'b0;
        #1;
        checks++; if (xpos !== 12'd0 || ypos !== 12'd0) begin
            errors++; $display("FAIL async_reset_pos: got %0d/%0d expected 0/0", xpos, ypos);
        end
        checks++; if (button !== 1'b0 || mouse_left !== 1'b0) begin
            errors++; $display("FAIL async_reset_pulses: got %b/%b expected 0/0", button, mouse_left);
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (button) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++; if (pulses !== 1 || first !== 19) begin
            errors++; $display("FAIL mid_post_reset: got %0d pulses at %0d expected 1 at 19", pulses, first);
        end
        @(negedge clk) button_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_click();
        test_button_bounce();
        test_button_short();
        test_position();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
